// File: rtl/dpfifo_ctrl_pkg.sv
// Shared sizing for the dual-port FIFO controller and its RAM.
// Holds width defaults and the depth derivation.
package dpfifo_ctrl_pkg;

   localparam int DW_DEF = 2;
   localparam int AW_DEF = 4;

   function automatic int depth_of(input int aw);
      return 1 << aw;
   endfunction

   localparam int DEPTH_DEF = depth_of(AW_DEF);

endpackage

// File: rtl/dpfifo_ctrl_if.sv
// Push/pop handshake and status bundle of the FIFO controller.
// master drives requests, slave is the controller.
interface dpfifo_ctrl_if
   import dpfifo_ctrl_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) ();

   logic          push;
   logic [DW-1:0] push_data;
   logic          pop;
   logic          pop_valid;
   logic [DW-1:0] pop_data;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;

   modport master (
      output push, push_data, pop,
      input  pop_valid, pop_data, full, empty,
      input  count, overflow, underflow
   );

   modport slave (
      input  push, push_data, pop,
      output pop_valid, pop_data, full, empty,
      output count, overflow, underflow
   );

endinterface

// File: rtl/dpfifo_ctrl_fifo_ptr.sv
// Modulo-2^AW address pointer for the FIFO RAM.
// Wraps naturally from the top address back to 0.
module fifo_ptr #(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   output logic [AW-1:0] ptr
);

   // advance by one on each accepted access
   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (inc)
         ptr <= ptr + AW'(1);
   end

endmodule

// File: rtl/dpfifo_ctrl.sv
// FIFO controller driving an external dual-port RAM.
// Port 1 writes at wr_ptr, port 2 reads at rd_ptr.
module dpfifo_ctrl
   import dpfifo_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DW_DEF,
   parameter int ADDR_WIDTH = AW_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   dpfifo_ctrl_if.slave          fifo,
   output logic                  ram_we1,
   output logic                  ram_oe1,
   output logic [ADDR_WIDTH-1:0] ram_addr1,
   output logic [DATA_WIDTH-1:0] ram_din1,
   output logic                  ram_we2,
   output logic                  ram_oe2,
   output logic [ADDR_WIDTH-1:0] ram_addr2,
   input  logic [DATA_WIDTH-1:0] ram_dout2
);

   localparam int DEPTH = depth_of(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] CNT_FULL =
      (ADDR_WIDTH+1)'(DEPTH);

   logic                  push_acc;
   logic                  pop_acc;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count_nxt;

   // accept only when there is room/data and not in reset
   always_comb begin
      push_acc = fifo.push & ~fifo.full & ~rst;
      pop_acc  = fifo.pop & ~fifo.empty & ~rst;
   end

   fifo_ptr #(.AW(ADDR_WIDTH)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .inc (push_acc),
      .ptr (wr_ptr)
   );

   fifo_ptr #(.AW(ADDR_WIDTH)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .inc (pop_acc),
      .ptr (rd_ptr)
   );

   // RAM strobes track acceptance so rejected requests never touch memory
   always_comb begin
      ram_we1   = push_acc;
      ram_oe1   = 1'b0;
      ram_addr1 = wr_ptr;
      ram_din1  = fifo.push_data;
      ram_we2   = 1'b0;
      ram_oe2   = pop_acc;
      ram_addr2 = rd_ptr;
   end

   // occupancy after this edge; both or neither leaves it unchanged
   always_comb begin
      count_nxt = fifo.count;
      case ({push_acc, pop_acc})
         2'b10:   count_nxt = fifo.count + 1'b1;
         2'b01:   count_nxt = fifo.count - 1'b1;
         default: count_nxt = fifo.count;
      endcase
   end

   // registered status, flags decoded from next count
   always_ff @(posedge clk) begin
      if (rst) begin
         fifo.count     <= '0;
         fifo.full      <= 1'b0;
         fifo.empty     <= 1'b1;
         fifo.pop_valid <= 1'b0;
         fifo.overflow  <= 1'b0;
         fifo.underflow <= 1'b0;
      end else begin
         fifo.count     <= count_nxt;
         fifo.full      <= (count_nxt == CNT_FULL);
         fifo.empty     <= (count_nxt == '0);
         fifo.pop_valid <= pop_acc;
         fifo.overflow  <= fifo.push & fifo.full;
         fifo.underflow <= fifo.pop & fifo.empty;
      end
   end

   // RAM data is only meaningful in the cycle after an accepted pop
   always_comb begin
      fifo.pop_data = fifo.pop_valid ? ram_dout2 : '0;
   end

endmodule

// File: tb/tb_dpfifo_ctrl.sv
// Directed bench for dpfifo_ctrl with a behavioural dual-port RAM.
// Expected pop words are queued at issue and compared by a monitor.
module tb_dpfifo_ctrl;

   localparam int DW = 2;
   localparam int AW = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          ram_we1, ram_oe1, ram_we2, ram_oe2;
   logic [AW-1:0] ram_addr1, ram_addr2;
   logic [DW-1:0] ram_din1;
   logic [DW-1:0] ram_dout2 = '0;
   logic [DW-1:0] mem [DEPTH];

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mq[$];
   logic [DW-1:0] exp_q[$];

   dpfifo_ctrl_if #(.DW(DW), .AW(AW)) fifo_if ();

   dpfifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .fifo      (fifo_if),
      .ram_we1   (ram_we1),
      .ram_oe1   (ram_oe1),
      .ram_addr1 (ram_addr1),
      .ram_din1  (ram_din1),
      .ram_we2   (ram_we2),
      .ram_oe2   (ram_oe2),
      .ram_addr2 (ram_addr2),
      .ram_dout2 (ram_dout2)
   );

   always #5 clk = ~clk;

   // registered-output dual-port RAM; reads 0 when not enabled
   always @(posedge clk) begin
      if (ram_we1) mem[ram_addr1] <= ram_din1;
      ram_dout2 <= ram_oe2 ? mem[ram_addr2] : '0;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   // monitor: compare every presented word against the scoreboard
   always @(negedge clk) begin
      if (fifo_if.pop_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_extra: got %0d expected none at %0t",
                     fifo_if.pop_data, $time);
         end else begin
            chk("pop_data", int'(fifo_if.pop_data),
                int'(exp_q.pop_front()));
         end
      end else if (rst === 1'b0) begin
         chk("pop_data_idle", int'(fifo_if.pop_data), 0);
      end
   end

   // one cycle of stimulus; starts just after a rising edge
   task automatic step(input logic p, input logic [DW-1:0] d,
                       input logic q);
      logic fb, eb, pa, qa;
      fb = (mq.size() == DEPTH);
      eb = (mq.size() == 0);
      pa = p && !fb;
      qa = q && !eb;
      fifo_if.push      = p;
      fifo_if.push_data = d;
      fifo_if.pop       = q;
      #1;
      chk("ram_we1", int'(ram_we1), int'(pa));
      chk("ram_oe2", int'(ram_oe2), int'(qa));
      if (qa) exp_q.push_back(mq.pop_front());
      if (pa) mq.push_back(d);
      @(posedge clk);
      #1;
      chk("count", int'(fifo_if.count), mq.size());
      chk("full", int'(fifo_if.full), int'(mq.size() == DEPTH));
      chk("empty", int'(fifo_if.empty), int'(mq.size() == 0));
      chk("overflow", int'(fifo_if.overflow), int'(p && fb));
      chk("underflow", int'(fifo_if.underflow), int'(q && eb));
      chk("pop_valid", int'(fifo_if.pop_valid), int'(qa));
      fifo_if.push = 1'b0;
      fifo_if.pop  = 1'b0;
   endtask

   // reset edge with a pop and push requested alongside
   task automatic do_reset();
      rst               = 1'b1;
      fifo_if.push      = 1'b1;
      fifo_if.push_data = 2'd3;
      fifo_if.pop       = 1'b1;
      #1;
      chk("rst_we1", int'(ram_we1), 0);
      chk("rst_oe2", int'(ram_oe2), 0);
      @(posedge clk);
      #1;
      mq.delete();
      chk("rst_count", int'(fifo_if.count), 0);
      chk("rst_empty", int'(fifo_if.empty), 1);
      chk("rst_full", int'(fifo_if.full), 0);
      chk("rst_pop_valid", int'(fifo_if.pop_valid), 0);
      chk("rst_overflow", int'(fifo_if.overflow), 0);
      chk("rst_underflow", int'(fifo_if.underflow), 0);
      rst          = 1'b0;
      fifo_if.push = 1'b0;
      fifo_if.pop  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      rst               = 1'b1;
      fifo_if.push      = 1'b0;
      fifo_if.push_data = '0;
      fifo_if.pop       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // reset then idle
      chk("idle_pop_data", int'(fifo_if.pop_data), 0);
      step(1'b0, 2'd0, 1'b0);

      // single word round trip
      step(1'b1, 2'b10, 1'b0);
      chk("rt_exp", int'(exp_q.size()), 0);
      step(1'b0, 2'd0, 1'b1);
      chk("rt_queued", int'(exp_q[0]), 2);
      step(1'b0, 2'd0, 1'b0);

      // fill, overflow, drain across the pointer wrap
      for (int i = 0; i < DEPTH; i++)
         step(1'b1, DW'(i % 4), 1'b0);
      chk("fill_count", int'(fifo_if.count), 16);
      step(1'b1, 2'd3, 1'b0);
      step(1'b1, 2'd2, 1'b1);
      step(1'b1, 2'd1, 1'b0);
      for (int i = 0; i < DEPTH; i++)
         step(1'b0, 2'd0, 1'b1);
      step(1'b0, 2'd0, 1'b0);

      // underflow cases
      step(1'b0, 2'd0, 1'b1);
      step(1'b1, 2'd1, 1'b1);
      step(1'b0, 2'd0, 1'b1);
      step(1'b0, 2'd0, 1'b0);

      // steady state at half full
      for (int i = 0; i < 8; i++)
         step(1'b1, DW'((i * 3) % 4), 1'b0);
      for (int i = 0; i < 20; i++)
         step(1'b1, DW'((i + 1) % 4), 1'b1);
      chk("steady_count", int'(fifo_if.count), 8);

      // reset mid-operation at count 5 with a pop pending
      for (int i = 0; i < 3; i++)
         step(1'b0, 2'd0, 1'b1);
      chk("pre_rst_count", int'(fifo_if.count), 5);
      do_reset();

      // operation resumes from pointer 0
      step(1'b1, 2'd1, 1'b0);
      step(1'b1, 2'd2, 1'b1);
      step(1'b0, 2'd0, 1'b1);
      step(1'b0, 2'd0, 1'b0);
      step(1'b0, 2'd0, 1'b0);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
